// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_enable,
  input  logic                        read_enable,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THRESH_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_THRESH_C = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] head_word;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_THRESH_C);
  assign almost_full  = (count_q >= AF_THRESH_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign head_word = mem_q[rd_ptr_q];

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  always_comb begin
    rd_accept   = read_enable && !empty;
    wr_accept   = write_enable && (!full || rd_accept);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = write_enable && full && !rd_accept;
    underflow_d = read_enable && empty;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : head_word;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
      data_out_d = data_out_q;
      if (rd_accept) begin
        data_out_d = head_word;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_out_q <= '0;
      end else begin
        data_out_q <= data_out_d;
      end
    end

    assign data_out = data_out_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read instance and an FWFT instance
// driven from hand-computed vectors, checked after each clock edge.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       writeEnable, readEnable;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       empty, full, almostEmpty, almostFull, overflow, underflow;
  logic [4:0] count;

  logic       writeEnableF, readEnableF;
  logic [7:0] dataInF;
  logic [7:0] dataOutF;
  logic       emptyF, fullF, almostEmptyF, almostFullF, overflowF, underflowF;
  logic [4:0] countF;

  int checkCount = 0;
  int errorCount = 0;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .write_enable(writeEnable), .read_enable(readEnable),
    .data_in(dataIn), .data_out(dataOut),
    .empty(empty), .full(full), .almost_empty(almostEmpty), .almost_full(almostFull),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) dutF (
    .clk(clk), .rst(rst),
    .write_enable(writeEnableF), .read_enable(readEnableF),
    .data_in(dataInF), .data_out(dataOutF),
    .empty(emptyF), .full(fullF), .almost_empty(almostEmptyF), .almost_full(almostFullF),
    .count(countF), .overflow(overflowF), .underflow(underflowF)
  );

  // One comparison: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests into the chosen instance, then sample 1 time unit after the edge.
  task automatic applyStimulus(input bit toFwft, input logic w, input logic r, input logic [7:0] d);
    if (toFwft) begin
      writeEnableF = w;
      readEnableF  = r;
      dataInF      = d;
    end else begin
      writeEnable = w;
      readEnable  = r;
      dataIn      = d;
    end
    @(posedge clk);
    #1;
    writeEnable  = 1'b0;
    readEnable   = 1'b0;
    writeEnableF = 1'b0;
    readEnableF  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    writeEnable  = 1'b0;
    readEnable   = 1'b0;
    dataIn       = 8'h00;
    writeEnableF = 1'b0;
    readEnableF  = 1'b0;
    dataInF      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Put some state in both instances, then reset asynchronously mid-cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("pre_reset_data", dataOut, 8'h11);
    checkOutput("pre_reset_count", count, 5'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h99);
    checkOutput("pre_reset_fwft_data", dataOutF, 8'h99);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("reset_count", count, 5'd0);
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_almost_empty", almostEmpty, 1'b1);
    checkOutput("reset_full", full, 1'b0);
    checkOutput("reset_almost_full", almostFull, 1'b0);
    checkOutput("reset_data", dataOut, 8'h00);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_underflow", underflow, 1'b0);
    checkOutput("reset_fwft_data", dataOutF, 8'h00);
    checkOutput("reset_fwft_empty", emptyF, 1'b1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_count", count, 5'd0);

    // Fill with 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i + 1));
      checkOutput("fill_count", count, 32'(i + 1));
      checkOutput("fill_almost_full", almostFull, 32'((i + 1) >= 14));
      checkOutput("fill_full", full, 32'((i + 1) == 16));
      checkOutput("fill_empty", empty, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("overflow_pulse", overflow, 1'b1);
    checkOutput("overflow_count", count, 5'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("overflow_clear", overflow, 1'b0);

    // Drain; the dropped 0xFF must never appear.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("drain_data", dataOut, 32'(i + 1));
      checkOutput("drain_count", count, 32'(15 - i));
      checkOutput("drain_almost_empty", almostEmpty, 32'((15 - i) <= 2));
      checkOutput("drain_empty", empty, 32'((15 - i) == 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("underflow_pulse", underflow, 1'b1);
    checkOutput("underflow_data_hold", dataOut, 8'h10);
    checkOutput("underflow_count", count, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("underflow_clear", underflow, 1'b0);

    // Wrap-around: move pointers to 10, then push 12 words across the 15->0 rollover.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("wrap_pre_data", dataOut, 32'(8'h30 + i));
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    checkOutput("wrap_count", count, 5'd12);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("wrap_data", dataOut, 32'(8'hA0 + i));
    end
    checkOutput("wrap_empty", empty, 1'b1);

    // Simultaneous write+read at full.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    checkOutput("full_before_both", full, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
    checkOutput("both_full_count", count, 5'd16);
    checkOutput("both_full_overflow", overflow, 1'b0);
    checkOutput("both_full_data", dataOut, 8'h60);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("both_full_drain", dataOut, 32'(8'h60 + i));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("both_full_last", dataOut, 8'h55);
    checkOutput("both_full_end_count", count, 5'd0);

    // Simultaneous write+read at empty.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    checkOutput("both_empty_underflow", underflow, 1'b1);
    checkOutput("both_empty_count", count, 5'd1);
    checkOutput("both_empty_data_hold", dataOut, 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("both_empty_read", dataOut, 8'h77);
    checkOutput("both_empty_underflow_clear", underflow, 1'b0);
    checkOutput("both_empty_final_count", count, 5'd0);

    // FWFT instance.
    checkOutput("fwft_idle_data", dataOutF, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    checkOutput("fwft_first_word", dataOutF, 8'h3C);
    checkOutput("fwft_count1", countF, 5'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h4D);
    checkOutput("fwft_head_stable", dataOutF, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_next_word", dataOutF, 8'h4D);
    checkOutput("fwft_count_after_read", countF, 5'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_empty_data", dataOutF, 8'h00);
    checkOutput("fwft_empty", emptyF, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_underflow", underflowF, 1'b1);
    checkOutput("fwft_underflow_data", dataOutF, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5E);
    checkOutput("fwft_both_empty_underflow", underflowF, 1'b1);
    checkOutput("fwft_both_empty_count", countF, 5'd1);
    checkOutput("fwft_both_empty_data", dataOutF, 8'h5E);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
